// File: rtl/task_clk_stepper.sv
// task_clk_stepper: host run/step/halt controller for the gated task clock.
// Releases the task clock either free-running or for an exact cycle count.
// clk_en is registered and feeds the task-clock BUFGCE enable term.
// break_in from the breakpoint logic overrides everything and halts at once.
module task_clk_stepper #(
  parameter int CNT_W = 64
) (
  input  logic             sys_clk,
  input  logic             sys_resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             break_in,
  output logic             clk_en,
  output logic             halted,
  output logic             done_valid,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycles_run
);

  // command opcodes
  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // response causes
  localparam logic [1:0] RSP_HALT  = 2'b00;
  localparam logic [1:0] RSP_DONE  = 2'b01;
  localparam logic [1:0] RSP_BREAK = 2'b10;
  localparam logic [1:0] RSP_REJ   = 2'b11;

  // FSM encoding
  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] cause;
  } rsp_t;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] remaining, rem_nx;
  rsp_t             rsp_nx;
  logic             clr_nx;
  logic             is_halt;
  logic             expire;

  // The controller never back-pressures; every valid command is taken.
  assign cmd_ready = 1'b1;
  assign halted    = (state == S_HALTED);

  assign is_halt = cmd_valid && (cmd_op == OP_HALT);
  // Last granted cycle of a STEP: full-width compare so huge counts are exact.
  assign expire  = clk_en && (remaining == CNT_W'(1));

  // Next-state / response decode. Forced halts (break, HALT, expiry) win over
  // any other command in the same cycle; a losing command is simply dropped.
  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    rsp_nx   = '0;
    clr_nx   = 1'b0;
    case (state)
      S_HALTED: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_HALT: begin
              rsp_nx = '{vld: 1'b1, cause: RSP_HALT};
            end
            OP_RUN: begin
              if (break_in) rsp_nx   = '{vld: 1'b1, cause: RSP_BREAK};
              else          state_nx = S_RUN;
            end
            OP_STEP: begin
              if (cmd_count == '0) begin
                rsp_nx = '{vld: 1'b1, cause: RSP_DONE};
              end else if (break_in) begin
                rsp_nx = '{vld: 1'b1, cause: RSP_BREAK};
              end else begin
                state_nx = S_STEP;
                rem_nx   = cmd_count;
              end
            end
            default: begin // OP_CLEAR
              clr_nx = 1'b1;
              rsp_nx = '{vld: 1'b1, cause: RSP_DONE};
            end
          endcase
        end
      end
      S_RUN, S_STEP: begin
        if (state == S_STEP && clk_en) rem_nx = remaining - CNT_W'(1);
        if (break_in) begin
          state_nx = S_HALTED;
          rem_nx   = '0;
          rsp_nx   = '{vld: 1'b1, cause: RSP_BREAK};
        end else if (is_halt) begin
          state_nx = S_HALTED;
          rem_nx   = '0;
          rsp_nx   = '{vld: 1'b1, cause: RSP_HALT};
        end else if (state == S_STEP && expire) begin
          state_nx = S_HALTED;
          rem_nx   = '0;
          rsp_nx   = '{vld: 1'b1, cause: RSP_DONE};
        end else if (cmd_valid) begin
          rsp_nx = '{vld: 1'b1, cause: RSP_REJ};
        end
      end
      default: begin
        state_nx = S_HALTED;
        rem_nx   = '0;
      end
    endcase
  end

  // FSM, step counter and registered clock enable. clk_en is derived from the
  // next state so a grant shows up the cycle after accept and a halt drops it
  // the cycle after the stop condition is seen.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state     <= S_HALTED;
      remaining <= '0;
      clk_en    <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= rem_nx;
      clk_en    <= (state_nx != S_HALTED);
    end
  end

  // One-cycle response pulse; cause reads 0 when no pulse is present.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      done_valid <= 1'b0;
      done_cause <= 2'b00;
    end else begin
      done_valid <= rsp_nx.vld;
      done_cause <= rsp_nx.cause;
    end
  end

  // Granted-cycle counter; wraps, cleared only by CLEAR while halted.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn)  cycles_run <= '0;
    else if (clr_nx)  cycles_run <= '0;
    else if (clk_en)  cycles_run <= cycles_run + CNT_W'(1);
  end

endmodule

// File: tb/tb_task_clk_stepper.sv
// Directed bench for task_clk_stepper: reset, STEP/RUN/HALT/CLEAR timing,
// break handling and priority, rejects, counter wrap, async reset mid-STEP.
module tb_task_clk_stepper;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        sys_clk;
  logic        sys_resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_count;
  logic        break_in;
  logic        clk_en;
  logic        halted;
  logic        done_valid;
  logic [1:0]  done_cause;
  logic [63:0] cycles_run;

  // narrow instance for the wrap check
  logic        w_cmd_valid;
  logic        w_cmd_ready;
  logic [1:0]  w_cmd_op;
  logic [3:0]  w_cmd_count;
  logic        w_break_in;
  logic        w_clk_en;
  logic        w_halted;
  logic        w_done_valid;
  logic [1:0]  w_done_cause;
  logic [3:0]  w_cycles_run;

  int n_chk  = 0;
  int n_pass = 0;

  task_clk_stepper #(.CNT_W(64)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .break_in(break_in), .clk_en(clk_en),
    .halted(halted), .done_valid(done_valid), .done_cause(done_cause),
    .cycles_run(cycles_run)
  );

  task_clk_stepper #(.CNT_W(4)) dut_w (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_op(w_cmd_op),
    .cmd_count(w_cmd_count), .break_in(w_break_in), .clk_en(w_clk_en),
    .halted(w_halted), .done_valid(w_done_valid), .done_cause(w_done_cause),
    .cycles_run(w_cycles_run)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // present one command for one edge; returns just after the accepting edge
  task automatic cmd(input logic [1:0] op, input logic [63:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_HALT;
    cmd_count = '0;
  endtask

  task automatic wcmd(input logic [1:0] op);
    w_cmd_valid = 1'b1;
    w_cmd_op    = op;
    tick();
    w_cmd_valid = 1'b0;
    w_cmd_op    = OP_HALT;
  endtask

  task automatic chk_done(input string tag, input logic [1:0] cause);
    chk({tag, "_vld"}, 64'(done_valid), 64'd1);
    chk({tag, "_cause"}, 64'(done_cause), 64'(cause));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_resetn  = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = OP_HALT;
    cmd_count   = '0;
    break_in    = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd_op    = OP_HALT;
    w_cmd_count = '0;
    w_break_in  = 1'b0;

    // reset values
    #12;
    chk("rst_clk_en", 64'(clk_en), 64'd0);
    chk("rst_halted", 64'(halted), 64'd1);
    chk("rst_done", 64'(done_valid), 64'd0);
    chk("rst_cause", 64'(done_cause), 64'd0);
    chk("rst_cycles", cycles_run, 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    sys_resetn = 1'b1;
    tick();

    // STEP 5: enabled exactly 5 cycles, then done 01
    cmd(OP_STEP, 64'd5);
    chk("s5_en", 64'(clk_en), 64'd1);
    chk("s5_halted", 64'(halted), 64'd0);
    n = 0;
    while (clk_en && n < 20) begin n++; tick(); end
    chk("s5_len", 64'(n), 64'd5);
    chk_done("s5_done", 2'b01);
    chk("s5_halted2", 64'(halted), 64'd1);
    chk("s5_cycles", cycles_run, 64'd5);
    tick();
    chk("s5_pulse1", 64'(done_valid), 64'd0);

    // HALT while halted, then CLEAR
    cmd(OP_HALT, 0);
    chk_done("hh", 2'b00);
    cmd(OP_CLEAR, 0);
    chk_done("clr", 2'b01);
    chk("clr_cycles", cycles_run, 64'd0);

    // RUN, HALT accepted exactly 100 edges later
    cmd(OP_RUN, 0);
    chk("run_en", 64'(clk_en), 64'd1);
    chk("run_nodone", 64'(done_valid), 64'd0);
    tick_n(99);
    chk("run_en99", 64'(clk_en), 64'd1);
    cmd(OP_HALT, 0);
    chk("rh_en", 64'(clk_en), 64'd0);
    chk_done("rh", 2'b00);
    chk("rh_cycles", cycles_run, 64'd100);

    // STEP 1000, break at enabled cycle 10
    cmd(OP_CLEAR, 0);
    cmd(OP_STEP, 64'd1000);
    tick_n(9);
    break_in = 1'b1;
    tick();
    chk("brk_en", 64'(clk_en), 64'd0);
    chk_done("brk", 2'b10);
    chk("brk_cycles", cycles_run, 64'd10);
    cmd(OP_RUN, 0);
    chk_done("brk_run", 2'b10);
    chk("brk_run_en", 64'(clk_en), 64'd0);
    tick_n(2);
    chk("brk_run_en2", 64'(clk_en), 64'd0);
    chk("brk_run_halted", 64'(halted), 64'd1);
    break_in = 1'b0;

    // STEP 3 with HALT and break on the final enabled cycle: single cause 10
    cmd(OP_STEP, 64'd3);
    tick_n(2);
    break_in = 1'b1;
    cmd(OP_HALT, 0);
    break_in = 1'b0;
    chk("pri_en", 64'(clk_en), 64'd0);
    chk_done("pri", 2'b10);
    tick();
    chk("pri_single", 64'(done_valid), 64'd0);

    // STEP 2 with a RUN on the expiry cycle: expiry pulse only, RUN dropped
    cmd(OP_STEP, 64'd2);
    tick();
    cmd(OP_RUN, 0);
    chk_done("exp_rej", 2'b01);
    chk("exp_rej_en", 64'(clk_en), 64'd0);
    tick();
    chk("exp_rej_single", 64'(done_valid), 64'd0);
    chk("exp_rej_halted", 64'(halted), 64'd1);

    // STEP 1 boundary
    cmd(OP_STEP, 64'd1);
    chk("s1_en", 64'(clk_en), 64'd1);
    tick();
    chk("s1_en_off", 64'(clk_en), 64'd0);
    chk_done("s1", 2'b01);

    // rejects while running, back to back
    cmd(OP_CLEAR, 0);
    cmd(OP_RUN, 0);
    cmd(OP_STEP, 64'd4);
    chk_done("rej_step", 2'b11);
    chk("rej_step_en", 64'(clk_en), 64'd1);
    cmd(OP_CLEAR, 0);
    chk_done("rej_clr", 2'b11);
    chk("rej_clr_cycles", cycles_run, 64'd2);
    cmd(OP_HALT, 0);
    chk_done("rej_halt", 2'b00);
    chk("rej_halt_cycles", cycles_run, 64'd3);
    cmd(OP_CLEAR, 0);
    chk_done("rej_clr2", 2'b01);
    chk("rej_clr2_cycles", cycles_run, 64'd0);

    // STEP 0
    cmd(OP_STEP, 64'd0);
    chk_done("s0", 2'b01);
    chk("s0_en", 64'(clk_en), 64'd0);
    chk("s0_halted", 64'(halted), 64'd1);

    // wrap on the 4-bit instance: 14, then +3 -> 1
    wcmd(OP_RUN);
    tick_n(13);
    wcmd(OP_HALT);
    chk("w_pre", 64'(w_cycles_run), 64'd14);
    wcmd(OP_RUN);
    tick_n(2);
    wcmd(OP_HALT);
    chk("w_wrap", 64'(w_cycles_run), 64'd1);
    chk("w_done", 64'(w_done_cause), 64'd0);

    // async reset mid-STEP
    cmd(OP_STEP, 64'd50);
    tick_n(3);
    chk("ar_pre_en", 64'(clk_en), 64'd1);
    #2 sys_resetn = 1'b0;
    #1;
    chk("ar_en", 64'(clk_en), 64'd0);
    chk("ar_halted", 64'(halted), 64'd1);
    chk("ar_done", 64'(done_valid), 64'd0);
    chk("ar_cause", 64'(done_cause), 64'd0);
    chk("ar_cycles", cycles_run, 64'd0);
    #2 sys_resetn = 1'b1;
    tick();
    chk("ar_post_en", 64'(clk_en), 64'd0);
    chk("ar_post_done", 64'(done_valid), 64'd0);
    chk("ar_post_halted", 64'(halted), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/task_clk_stepper.md
# task_clk_stepper

Host-driven run/step/halt controller for the gated task clock. It is the release side of the breakpoint path: the breakpoint logic stops the DUT's task clock, and this block grants the clock again, either free-running or for an exact number of cycles. Its registered `clk_en` output feeds the task-clock BUFGCE enable term. `break_in` from the breakpoint logic forces an immediate halt.

## Interface
- `CNT_W`, default 64: width of the step count and the run-cycle counter.
- `sys_clk` input 1: system clock; the gated task clock derives from it.
- `sys_resetn` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accept; constant 1 after reset.
- `cmd_op` input 2: command opcode.
  - 00 = HALT
  - 01 = RUN
  - 10 = STEP
  - 11 = CLEAR
- `cmd_count` input CNT_W: STEP length in task-clock cycles; sampled at accept.
- `break_in` input 1: breakpoint/difftest stop request, level.
- `clk_en` output 1: task clock enable, registered.
- `halted` output 1: high when the FSM is in HALTED.
- `done_valid` output 1: one-cycle completion/response pulse.
- `done_cause` output 2: valid with `done_valid`.
  - 00 = halt cmd
  - 01 = step complete / clear done
  - 10 = break
  - 11 = rejected
- `cycles_run` output CNT_W: count of cycles with `clk_en`=1; wraps modulo 2^CNT_W.

## Operation
- States: HALTED, RUN, STEP. Reset enters HALTED.
- Reset values:
  - `clk_en`=0, `halted`=1, `done_valid`=0, `done_cause`=0, `cycles_run`=0.
  - Internal `remaining`=0.
- Accept rule: accept occurs at an edge where `cmd_valid`=1 (`cmd_ready` is always 1). Every accepted command produces exactly one `done_valid` pulse, except RUN, which pulses only when it ends.
- HALTED:
  - RUN: go to RUN.
  - STEP with N>0: load `remaining`=N and go to STEP.
  - STEP with N=0: stay HALTED; pulse done cause 01.
  - CLEAR: `cycles_run`<=0; pulse done cause 01.
  - HALT: no state change; pulse done cause 00.
- RUN:
  - HALT: go to HALTED; done cause 00.
  - RUN, STEP or CLEAR: rejected. No state change; done cause 11.
- STEP:
  - Each cycle with `clk_en`=1 decrements `remaining`.
  - When `remaining`=1 and `clk_en`=1: go to HALTED; done cause 01.
  - HALT: go to HALTED; done cause 00.
  - Other ops: rejected, cause 11.
- Break handling:
  - `break_in`=1 in RUN or STEP forces HALTED with done cause 10.
  - In HALTED, a RUN or STEP (N>0) accepted while `break_in`=1 is rejected with cause 10 and the FSM stays halted.
  - CLEAR and HALT are unaffected by `break_in`.
- Priority in the same cycle: `break_in` > HALT cmd > step-count expiry > other commands. If a rejected command coincides with a forced halt, only the forced-halt pulse is emitted; the command is dropped.
- `cycles_run` increments in every cycle where `clk_en`=1; no saturation. `remaining` compares at full CNT_W width.

## Timing
- Command accepted at edge k (RUN, or STEP N>0): `clk_en`=1 and `halted`=0 from k+1.
- STEP N: `clk_en` is high for exactly N cycles, k+1 .. k+N.
  - At k+N+1: `clk_en`=0, `halted`=1, `done_valid`=1 with cause 01.
  - `cycles_run` has advanced by exactly N.
- HALT accepted at edge k in RUN/STEP: `clk_en`=0 and done pulse at k+1.
- `break_in` sampled high at edge k: `clk_en`=0 and done pulse cause 10 at k+1. At most one enabled cycle occurs after the break is observed.
- Immediate responses (rejects, CLEAR, HALT while halted, STEP 0): `done_valid` at k+1. CLEAR takes effect with `cycles_run`=0 at k+1.
- `done_valid` is high for exactly one cycle per event. Back-to-back commands on consecutive cycles are each responded to.
- Asynchronous reset mid-RUN/STEP: `clk_en` drops immediately, with no done pulse. The FSM leaves reset in HALTED.

## Test plan
- Reset, then STEP `cmd_count`=5 → `clk_en` high exactly 5 cycles; done cause 01 on the 6th cycle after accept; `cycles_run`=5.
- RUN, wait 100 cycles, HALT → `clk_en` low the cycle after accept; cause 00; `cycles_run`=100 ± alignment (exactly 100 if HALT is accepted at edge k+100).
- STEP 1000, raise `break_in` at enabled cycle 10 → `clk_en` low next cycle; cause 10; `cycles_run`=10. Then RUN with `break_in` still high → cause 10 and `clk_en` stays 0.
- STEP 3 with HALT and `break_in` both arriving on the final enabled cycle → a single done pulse with cause 10.
- In RUN, issue STEP 4 and CLEAR → each gets cause 11; RUN continues and `cycles_run` is not cleared. After HALT, CLEAR → `cycles_run`=0 with cause 01.
- STEP `cmd_count`=0 → no `clk_en` pulse; done cause 01 at k+1. Preload `cycles_run` to 2^CNT_W−2, RUN 3 cycles → wraps to 1. Assert `sys_resetn`=0 mid-STEP → `clk_en` falls asynchronously; all outputs return to reset values.
